dma_engine: RTL

Single-channel word-copy DMA engine for the test SoC. It has two bus faces. It is a bus device: a register slave, decoded by the bus like the timer and console, through which the core programs source, destination and length. It is also a bus host: an initiator on its own host port, which reads words from the source and writes them to the destination through the shared bus. It raises a level interrupt on completion and lets the core offload block copies such as RAM-to-RAM buffers.

---
 rtl/dma_engine.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/dma_engine.sv
// Single-channel word-copy DMA engine: register slave for programming and bus
// host for the copy itself. Level interrupt while DONE is set.
module dma_engine #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32,
  parameter int unsigned LenWidth     = 20
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic                    req_in,
  input  logic                    we_in,
  input  logic [AddressWidth-1:0] addr_in,
  input  logic [DataWidth-1:0]    wdata_in,
  output logic [DataWidth-1:0]    rdata_out,
  output logic                    h_req_out,
  output logic [AddressWidth-1:0] h_addr_out,
  output logic                    h_we_out,
  output logic [DataWidth-1:0]    h_wdata_out,
  input  logic                    h_gnt_in,
  input  logic [DataWidth-1:0]    h_rdata_in,
  output logic                    irq_out
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_REQ  = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_WR_REQ  = 2'd3
  } state_e;

  localparam logic [1:0] RegSrc  = 2'd0;
  localparam logic [1:0] RegDst  = 2'd1;
  localparam logic [1:0] RegLen  = 2'd2;
  localparam logic [1:0] RegCtrl = 2'd3;

  localparam int unsigned CtrlStart = 0;
  localparam int unsigned CtrlClr   = 1;
  localparam int unsigned CtrlAbort = 2;

  localparam logic [AddressWidth-1:0] WordBytes = AddressWidth'(4);
  localparam logic [AddressWidth-1:0] AlignMask = ~AddressWidth'(3);
  localparam logic [LenWidth-1:0]     LenOne    = LenWidth'(1);

  state_e                  state_q, state_d;
  logic [AddressWidth-1:0] src_q, src_d;
  logic [AddressWidth-1:0] dst_q, dst_d;
  logic [LenWidth-1:0]     len_q, len_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    abort_q, abort_d;
  logic [DataWidth-1:0]    rdata_q, rdata_d;
  logic                    h_req_q, h_req_d;
  logic                    h_we_q, h_we_d;
  logic [AddressWidth-1:0] h_addr_q, h_addr_d;
  logic [DataWidth-1:0]    h_wdata_q, h_wdata_d;

  logic                    busy_c;
  logic                    dev_wr_c;
  logic                    dev_rd_c;
  logic [1:0]              sel_c;
  logic                    start_c;
  logic                    clr_c;
  logic                    abort_wr_c;
  logic [AddressWidth-1:0] wr_addr_c;
  logic [AddressWidth-1:0] src_inc_c;
  logic [AddressWidth-1:0] dst_inc_c;
  logic                    unused_addr_c;

  // Device-side decode; only addr_in[3:2] selects a register.
  assign busy_c        = (state_q != ST_IDLE);
  assign dev_wr_c      = req_in & we_in;
  assign dev_rd_c      = req_in & ~we_in;
  assign sel_c         = addr_in[3:2];
  assign start_c       = dev_wr_c && (sel_c == RegCtrl) && wdata_in[CtrlStart];
  assign clr_c         = dev_wr_c && (sel_c == RegCtrl) && wdata_in[CtrlClr];
  assign abort_wr_c    = dev_wr_c && (sel_c == RegCtrl) && wdata_in[CtrlAbort];
  assign wr_addr_c     = AddressWidth'(wdata_in) & AlignMask;
  assign src_inc_c     = src_q + WordBytes;
  assign dst_inc_c     = dst_q + WordBytes;
  assign unused_addr_c = ^{addr_in[AddressWidth-1:4], addr_in[1:0]};

  // Register file, copy sequencing and host-port drive.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    done_d    = done_q;
    err_d     = err_q;
    abort_d   = abort_q;
    rdata_d   = rdata_q;
    h_req_d   = h_req_q;
    h_we_d    = h_we_q;
    h_addr_d  = h_addr_q;
    h_wdata_d = h_wdata_q;

    if (dev_wr_c && !busy_c) begin
      case (sel_c)
        RegSrc:  src_d = wr_addr_c;
        RegDst:  dst_d = wr_addr_c;
        RegLen:  len_d = LenWidth'(wdata_in);
        default: ;
      endcase
    end

    if (clr_c) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end

    if (abort_wr_c && busy_c) begin
      abort_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          if (len_q != '0) begin
            state_d  = ST_RD_REQ;
            done_d   = 1'b0;
            err_d    = 1'b0;
            abort_d  = 1'b0;
            h_req_d  = 1'b1;
            h_we_d   = 1'b0;
            h_addr_d = src_q;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      ST_RD_REQ: begin
        if (h_gnt_in) begin
          state_d = ST_RD_WAIT;
          h_req_d = 1'b0;
        end
      end

      // Read data arrives the cycle after the grant; h_wdata_q is the buffer.
      ST_RD_WAIT: begin
        state_d   = ST_WR_REQ;
        h_wdata_d = h_rdata_in;
        h_req_d   = 1'b1;
        h_we_d    = 1'b1;
        h_addr_d  = dst_q;
      end

      ST_WR_REQ: begin
        if (h_gnt_in) begin
          src_d = src_inc_c;
          dst_d = dst_inc_c;
          len_d = len_q - LenOne;
          if (len_q == LenOne) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            abort_d = 1'b0;
            h_req_d = 1'b0;
            h_we_d  = 1'b0;
          end else if (abort_q || abort_wr_c) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
            abort_d = 1'b0;
            h_req_d = 1'b0;
            h_we_d  = 1'b0;
          end else begin
            state_d  = ST_RD_REQ;
            h_req_d  = 1'b1;
            h_we_d   = 1'b0;
            h_addr_d = src_inc_c;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Reads return the pre-edge working values.
    if (dev_rd_c) begin
      case (sel_c)
        RegSrc:  rdata_d = DataWidth'(src_q);
        RegDst:  rdata_d = DataWidth'(dst_q);
        RegLen:  rdata_d = DataWidth'(len_q);
        default: rdata_d = DataWidth'({err_q, done_q, busy_c});
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q   <= ST_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      abort_q   <= 1'b0;
      rdata_q   <= '0;
      h_req_q   <= 1'b0;
      h_we_q    <= 1'b0;
      h_addr_q  <= '0;
      h_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      done_q    <= done_d;
      err_q     <= err_d;
      abort_q   <= abort_d;
      rdata_q   <= rdata_d;
      h_req_q   <= h_req_d;
      h_we_q    <= h_we_d;
      h_addr_q  <= h_addr_d;
      h_wdata_q <= h_wdata_d;
    end
  end

  assign rdata_out   = rdata_q;
  assign h_req_out   = h_req_q;
  assign h_we_out    = h_we_q;
  assign h_addr_out  = h_addr_q;
  assign h_wdata_out = h_wdata_q;
  assign irq_out     = done_q;

endmodule
